// File: rtl/cpu_types.sv
// Shared CPU types for the reservation-station slice: slot identities, opcodes,
// the dispatched task layout and the slot state encoding.
package cpu_types;

   localparam int CPU_XLEN  = 32;
   localparam int CPU_TAG_W = 4;

   typedef enum logic [2:0] {
      INVALID = 3'd0,
      STORE_1 = 3'd1,
      STORE_2 = 3'd2,
      LOAD_1  = 3'd3,
      LOAD_2  = 3'd4,
      ALU_1   = 3'd5,
      ALU_2   = 3'd6
   } RS_tag_type;

   typedef enum logic [2:0] {
      NOP    = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      ALU    = 3'd3,
      BRANCH = 3'd4
   } opcode_t;

   typedef struct packed {
      logic                 rdy;
      logic [CPU_TAG_W-1:0] tag;
      logic [CPU_XLEN-1:0]  val;
   } operand_t;

   typedef struct packed {
      opcode_t              opcode;
      logic [3:0]           func;
      logic [CPU_TAG_W-1:0] dest_tag;
      operand_t             src1;
      operand_t             src2;
      logic [CPU_XLEN-1:0]  imm;
   } rs_task_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_OPS = 2'd1,
      ISSUE    = 2'd2
   } rs_state_t;

   function automatic logic operands_ready(input rs_task_t t);
      return t.src1.rdy & t.src2.rdy;
   endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Functional-unit handshake between a reservation-station slot (master)
// and its functional unit (slave).
interface reservation_station_if;
   import cpu_types::*;

   logic     FU_VALID;
   logic     FU_READY;
   rs_task_t FU_TASK;

   modport master (output FU_VALID, output FU_TASK, input FU_READY);
   modport slave  (input FU_VALID, input FU_TASK, output FU_READY);
endinterface

// File: rtl/reservation_station_checker.sv
// Protocol checks for one reservation-station slot: dispatch into an occupied
// slot and FU task stability under backpressure.
module reservation_station_checker
   import cpu_types::*;
#(
   parameter RS_tag_type MY_TAG = ALU_1
)
(
   input logic       CLK,
   input logic       RST,
   input logic       FLUSH,
   input logic       BUSY,
   input logic       FU_VALID,
   input logic       FU_READY,
   input RS_tag_type DEST_RS,
   input rs_task_t   FU_TASK
);

   // The dispatcher must never target an occupied slot
   a_dispatch_busy: assert property (@(posedge CLK) disable iff (RST)
      (DEST_RS == MY_TAG) |-> !BUSY)
      else $error("dispatch to busy RS");

   // An offered task stays put until taken, unless squashed
   a_fu_hold: assert property (@(posedge CLK) disable iff (RST)
      (FU_VALID && !FU_READY && !FLUSH) |=> (FU_VALID && $stable(FU_TASK)))
      else $error("FU task changed before handshake");

endmodule

// File: rtl/rs_operand_capture.sv
// Operand snoop: a pending operand whose producer tag matches a valid CDB
// broadcast takes the broadcast value and becomes ready.
module rs_operand_capture
   import cpu_types::*;
(
   input  operand_t             op_in,
   input  logic                 cdb_valid,
   input  logic [CPU_TAG_W-1:0] cdb_tag,
   input  logic [CPU_XLEN-1:0]  cdb_data,
   output operand_t             op_out
);

   // Fill a pending operand from a matching broadcast
   always_comb begin
      op_out = op_in;
      if (!op_in.rdy && cdb_valid && (cdb_tag == op_in.tag)) begin
         op_out.rdy = 1'b1;
         op_out.val = cdb_data;
      end else begin
         op_out = op_in;
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Single reservation-station slot: accepts a dispatched task, snoops the CDB for
// missing operands and offers the task to its FU. RS_PERF_CNT_EN adds WAIT_CYCLES.
module reservation_station
   import cpu_types::*;
#(
   parameter int         XLEN   = CPU_XLEN,
   parameter int         TAG_W  = CPU_TAG_W,
   parameter RS_tag_type MY_TAG = ALU_1
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  rs_task_t             DISPATCH_TASK,
   input  RS_tag_type           DEST_RS,
   input  logic                 FLUSH,
   input  logic                 CDB_VALID,
   input  logic [TAG_W-1:0]     CDB_TAG,
   input  logic [XLEN-1:0]      CDB_DATA,
   output logic                 BUSY,
   reservation_station_if.master fu
`ifdef RS_PERF_CNT_EN
   ,
   output logic [15:0]          WAIT_CYCLES
`endif
);

   rs_state_t state_r;
   rs_state_t state_nxt_s;
   rs_task_t  task_r;
   rs_task_t  task_nxt_s;
   logic      busy_r;
   logic      fu_valid_r;
   logic      accept_s;
   operand_t  cap_in1_s;
   operand_t  cap_in2_s;
   operand_t  cap_out1_s;
   operand_t  cap_out2_s;

   assign accept_s = (state_r == IDLE) && (DEST_RS == MY_TAG);

   // Snoop the incoming task while idle so a same-cycle broadcast is not lost
   always_comb begin
      cap_in1_s = task_r.src1;
      cap_in2_s = task_r.src2;
      if (state_r == IDLE) begin
         cap_in1_s = DISPATCH_TASK.src1;
         cap_in2_s = DISPATCH_TASK.src2;
         if (DISPATCH_TASK.opcode == LOAD) begin
            cap_in2_s.rdy = 1'b1;
         end else begin
            cap_in2_s.rdy = DISPATCH_TASK.src2.rdy;
         end
      end else begin
         cap_in1_s = task_r.src1;
         cap_in2_s = task_r.src2;
      end
   end

   rs_operand_capture u_cap_src1 (
      .op_in     (cap_in1_s),
      .cdb_valid (CDB_VALID),
      .cdb_tag   (CDB_TAG),
      .cdb_data  (CDB_DATA),
      .op_out    (cap_out1_s)
   );

   rs_operand_capture u_cap_src2 (
      .op_in     (cap_in2_s),
      .cdb_valid (CDB_VALID),
      .cdb_tag   (CDB_TAG),
      .cdb_data  (CDB_DATA),
      .op_out    (cap_out2_s)
   );

   // Next state and held task; FLUSH overrides accept and handshake
   always_comb begin
      state_nxt_s = state_r;
      task_nxt_s  = task_r;
      if (FLUSH) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  task_nxt_s      = DISPATCH_TASK;
                  task_nxt_s.src1 = cap_out1_s;
                  task_nxt_s.src2 = cap_out2_s;
                  state_nxt_s     = operands_ready(task_nxt_s) ? ISSUE : WAIT_OPS;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            WAIT_OPS: begin
               task_nxt_s.src1 = cap_out1_s;
               task_nxt_s.src2 = cap_out2_s;
               state_nxt_s     = operands_ready(task_nxt_s) ? ISSUE : WAIT_OPS;
            end
            ISSUE: begin
               if (fu.FU_READY) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // State, held task and registered status outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= IDLE;
         task_r     <= '0;
         busy_r     <= 1'b0;
         fu_valid_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         task_r     <= task_nxt_s;
         busy_r     <= (state_nxt_s != IDLE);
         fu_valid_r <= (state_nxt_s == ISSUE);
      end
   end

   assign BUSY        = busy_r;
   assign fu.FU_VALID = fu_valid_r;
   assign fu.FU_TASK  = task_r;

`ifdef RS_PERF_CNT_EN
   logic [15:0] wait_cycles_r;

   // Saturating count of cycles stalled on operands or on the FU
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wait_cycles_r <= 16'h0000;
      end else if (((state_r == WAIT_OPS) || ((state_r == ISSUE) && !fu.FU_READY))
                   && (wait_cycles_r != 16'hFFFF)) begin
         wait_cycles_r <= wait_cycles_r + 16'd1;
      end else begin
         wait_cycles_r <= wait_cycles_r;
      end
   end

   assign WAIT_CYCLES = wait_cycles_r;
`endif

   reservation_station_checker #(.MY_TAG(MY_TAG)) u_checker (
      .CLK      (CLK),
      .RST      (RST),
      .FLUSH    (FLUSH),
      .BUSY     (busy_r),
      .FU_VALID (fu_valid_r),
      .FU_READY (fu.FU_READY),
      .DEST_RS  (DEST_RS),
      .FU_TASK  (task_r)
   );

endmodule

// File: tb/tb_reservation_station.sv
// Bench for the ALU_1 reservation-station slot: directed vector table, hand
// sequences for backpressure/async reset, and a randomized run against a model.
module tb_reservation_station;
   import cpu_types::*;

   logic        clk;
   logic        rst;
   rs_task_t    dispatch;
   RS_tag_type  dest_rs;
   logic        flush;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        busy;
`ifdef RS_PERF_CNT_EN
   logic [15:0] wait_cycles;
`endif

   reservation_station_if fu_bus ();

   reservation_station #(.XLEN(32), .TAG_W(4), .MY_TAG(ALU_1)) dut (
      .CLK           (clk),
      .RST           (rst),
      .DISPATCH_TASK (dispatch),
      .DEST_RS       (dest_rs),
      .FLUSH         (flush),
      .CDB_VALID     (cdb_valid),
      .CDB_TAG       (cdb_tag),
      .CDB_DATA      (cdb_data),
      .BUSY          (busy),
      .fu            (fu_bus)
`ifdef RS_PERF_CNT_EN
      ,
      .WAIT_CYCLES   (wait_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      RS_tag_type  dest;
      opcode_t     op;
      logic        s1r;
      logic [3:0]  s1t;
      logic [31:0] s1v;
      logic        s2r;
      logic [3:0]  s2t;
      logic [31:0] s2v;
      logic        cv;
      logic [3:0]  ct;
      logic [31:0] cd;
      logic        rdy;
      logic        fl;
      logic        e_busy;
      logic        e_valid;
      logic [31:0] e_s1;
      logic [31:0] e_s2;
   } vec_t;

   vec_t vt[$];

   // Reference model state: is a task held, and what it currently looks like
   bit          m_held;
   rs_task_t    m_t;
   int unsigned m_wait;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic rs_task_t mk_task(opcode_t op, logic s1r, logic [3:0] s1t, logic [31:0] s1v,
                                        logic s2r, logic [3:0] s2t, logic [31:0] s2v);
      rs_task_t t;
      t          = '0;
      t.opcode   = op;
      t.func     = 4'h3;
      t.dest_tag = 4'hA;
      t.src1.rdy = s1r;
      t.src1.tag = s1t;
      t.src1.val = s1v;
      t.src2.rdy = s2r;
      t.src2.tag = s2t;
      t.src2.val = s2v;
      t.imm      = 32'h0000_0100;
      return t;
   endfunction

   task automatic add(RS_tag_type dest, opcode_t op, int s1r, int s1t, int s1v, int s2r, int s2t, int s2v,
                      int cv, int ct, int cd, int rdy, int fl, int eb, int ev, int e1, int e2);
      vec_t v;
      v.dest = dest;   v.op = op;
      v.s1r = 1'(s1r); v.s1t = 4'(s1t); v.s1v = 32'(s1v);
      v.s2r = 1'(s2r); v.s2t = 4'(s2t); v.s2v = 32'(s2v);
      v.cv = 1'(cv);   v.ct = 4'(ct);   v.cd = 32'(cd);
      v.rdy = 1'(rdy); v.fl = 1'(fl);
      v.e_busy = 1'(eb); v.e_valid = 1'(ev); v.e_s1 = 32'(e1); v.e_s2 = 32'(e2);
      vt.push_back(v);
   endtask

   task automatic set_idle();
      dispatch  = '0;
      dest_rs   = INVALID;
      flush     = 1'b0;
      cdb_valid = 1'b0;
      cdb_tag   = 4'h0;
      cdb_data  = 32'h0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Called one time unit after a rising edge; RST spans the next edge
   task automatic do_reset();
      set_idle();
      #1 rst = 1'b1;
      #1;
      chk("async reset busy", busy, 1'b0);
      chk("async reset fu_valid", fu_bus.FU_VALID, 1'b0);
      chk("async reset fu_task", fu_bus.FU_TASK, '0);
`ifdef RS_PERF_CNT_EN
      chk("async reset wait_cycles", wait_cycles, 16'h0);
`endif
      #9 rst = 1'b0;
   endtask

   function automatic operand_t snoop(operand_t o);
      if (!o.rdy && cdb_valid && (cdb_tag == o.tag)) begin
         o.rdy = 1'b1;
         o.val = cdb_data;
      end
      return o;
   endfunction

   task automatic model_step();
      bit offered;
      offered = m_held && m_t.src1.rdy && m_t.src2.rdy;
      if (m_held && !(offered && fu_bus.FU_READY) && (m_wait < 32'd65535)) m_wait++;
      if (flush) begin
         m_held = 1'b0;
      end else if (!m_held) begin
         if (dest_rs == ALU_1) begin
            m_t = dispatch;
            if (dispatch.opcode == LOAD) m_t.src2.rdy = 1'b1;
            m_t.src1 = snoop(m_t.src1);
            m_t.src2 = snoop(m_t.src2);
            m_held   = 1'b1;
         end
      end else if (offered) begin
         if (fu_bus.FU_READY) m_held = 1'b0;
      end else begin
         m_t.src1 = snoop(m_t.src1);
         m_t.src2 = snoop(m_t.src2);
      end
   endtask

   task automatic model_check(input int k);
      bit exp_valid;
      exp_valid = m_held && m_t.src1.rdy && m_t.src2.rdy;
      chk($sformatf("rnd%0d busy", k), busy, m_held);
      chk($sformatf("rnd%0d fu_valid", k), fu_bus.FU_VALID, exp_valid);
      if (exp_valid) chk($sformatf("rnd%0d fu_task", k), fu_bus.FU_TASK, m_t);
`ifdef RS_PERF_CNT_EN
      chk($sformatf("rnd%0d wait_cycles", k), wait_cycles, m_wait);
`endif
   endtask

   RS_tag_type others[6] = '{INVALID, STORE_1, STORE_2, LOAD_1, LOAD_2, ALU_2};
   opcode_t    ops[3]    = '{LOAD, STORE, ALU};
   rs_task_t   bp_task;

   initial begin
      rst = 1'b1;
      fu_bus.FU_READY = 1'b0;
      set_idle();
      #8;
      chk("reset busy", busy, 1'b0);
      chk("reset fu_valid", fu_bus.FU_VALID, 1'b0);
      chk("reset fu_task", fu_bus.FU_TASK, '0);
      #4 rst = 1'b0;

      //   dest     op     s1r s1t s1v    s2r s2t s2v  cv ct cd       rdy fl  eb ev e1       e2
      add(ALU_1,   ALU,   1,  0,  5,     1,  0,  7,   0, 0, 0,        1,  0,  1, 1, 5,       7);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      add(ALU_1,   ALU,   0,  3,  0,     1,  0,  7,   0, 0, 0,        0,  0,  1, 0, 0,       0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        0,  0,  1, 0, 0,       0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   1, 3, 'hDEAD,   0,  0,  1, 1, 'hDEAD,  7);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      // dispatch/broadcast race on src2
      add(ALU_1,   ALU,   1,  0,  11,    0,  9,  0,   1, 9, 42,       0,  0,  1, 1, 11,      42);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      // one broadcast feeds both sources; a wrong tag first
      add(ALU_1,   ALU,   0,  6,  0,     0,  6,  0,   0, 0, 0,        0,  0,  1, 0, 0,       0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   1, 5, 1,        0,  0,  1, 0, 0,       0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   1, 6, 'h1234,   0,  0,  1, 1, 'h1234,  'h1234);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        0,  0,  1, 1, 'h1234,  'h1234);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      add(LOAD_2,  ALU,   1,  0,  1,     1,  0,  2,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      // LOAD ignores src2 even if the bus carries its tag
      add(ALU_1,   LOAD,  1,  0,  100,   0,  2,  0,   1, 2, 55,       0,  0,  1, 1, 100,     0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      add(ALU_1,   ALU,   0,  4,  0,     1,  0,  3,   0, 0, 0,        0,  0,  1, 0, 0,       0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        0,  1,  0, 0, 0,       0);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   1, 4, 9,        0,  0,  0, 0, 0,       0);
      add(ALU_1,   ALU,   1,  0,  1,     1,  0,  1,   0, 0, 0,        0,  1,  0, 0, 0,       0);
      add(ALU_1,   ALU,   1,  0,  8,     1,  0,  9,   0, 0, 0,        0,  0,  1, 1, 8,       9);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  1,  0, 0, 0,       0);
      // reuse one cycle after each handshake
      add(ALU_1,   ALU,   1,  0,  31,    1,  0,  32,  0, 0, 0,        1,  0,  1, 1, 31,      32);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);
      add(ALU_1,   STORE, 1,  0,  41,    1,  0,  42,  0, 0, 0,        1,  0,  1, 1, 41,      42);
      add(INVALID, NOP,   0,  0,  0,     0,  0,  0,   0, 0, 0,        1,  0,  0, 0, 0,       0);

      foreach (vt[i]) begin
         dispatch  = mk_task(vt[i].op, vt[i].s1r, vt[i].s1t, vt[i].s1v, vt[i].s2r, vt[i].s2t, vt[i].s2v);
         dest_rs   = vt[i].dest;
         cdb_valid = vt[i].cv;
         cdb_tag   = vt[i].ct;
         cdb_data  = vt[i].cd;
         flush     = vt[i].fl;
         fu_bus.FU_READY = vt[i].rdy;
         cycle();
         chk($sformatf("row%0d busy", i), busy, vt[i].e_busy);
         chk($sformatf("row%0d fu_valid", i), fu_bus.FU_VALID, vt[i].e_valid);
         if (vt[i].e_valid) begin
            chk($sformatf("row%0d src1_val", i), fu_bus.FU_TASK.src1.val, vt[i].e_s1);
            chk($sformatf("row%0d src2_val", i), fu_bus.FU_TASK.src2.val, vt[i].e_s2);
         end
      end

      // Backpressure: four cycles of FU_READY=0 with the task held steady
      do_reset();
      bp_task  = mk_task(ALU, 1'b1, 4'h0, 32'h11, 1'b1, 4'h0, 32'h22);
      dispatch = bp_task;
      dest_rs  = ALU_1;
      fu_bus.FU_READY = 1'b0;
      cycle();
      set_idle();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp%0d fu_valid", i), fu_bus.FU_VALID, 1'b1);
         chk($sformatf("bp%0d fu_task", i), fu_bus.FU_TASK, bp_task);
         cycle();
      end
`ifdef RS_PERF_CNT_EN
      chk("bp wait_cycles before handshake", wait_cycles, 16'd4);
`endif
      fu_bus.FU_READY = 1'b1;
      cycle();
      chk("bp busy after handshake", busy, 1'b0);
      chk("bp fu_valid after handshake", fu_bus.FU_VALID, 1'b0);
`ifdef RS_PERF_CNT_EN
      chk("bp wait_cycles", wait_cycles, 16'd4);
`endif

      // Reset raised mid-ISSUE must clear outputs before the next edge
      dispatch = mk_task(ALU, 1'b1, 4'h0, 32'h77, 1'b1, 4'h0, 32'h88);
      dest_rs  = ALU_1;
      fu_bus.FU_READY = 1'b0;
      cycle();
      chk("pre-reset fu_valid", fu_bus.FU_VALID, 1'b1);
      do_reset();

      // Randomized run against the reference model
      m_held = 1'b0;
      m_t    = '0;
      m_wait = 0;
      for (int k = 0; k < 3000; k++) begin
         int r;
         r = $urandom_range(0, 99);
         dest_rs   = (!m_held && r < 45) ? ALU_1 : others[$urandom_range(0, 5)];
         dispatch  = mk_task(ops[$urandom_range(0, 2)],
                             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
                             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
         cdb_valid = ($urandom_range(0, 1) == 1);
         cdb_tag   = 4'($urandom_range(0, 3));
         cdb_data  = $urandom;
         flush     = ($urandom_range(0, 99) < 3);
         fu_bus.FU_READY = ($urandom_range(0, 9) < 6);
         model_step();
         cycle();
         model_check(k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Single reservation-station slot, instantiated six times: STORE_1, STORE_2, LOAD_1, LOAD_2, ALU_1, ALU_2.
- Receiving end of the issue-queue dispatch interface. It accepts one task when the dispatcher's destination tag matches its own tag.
- Snoops the common data bus (CDB) for missing operands, then hands the task to its functional unit with a valid/ready handshake.
- Drives its bit of the dispatcher's rs_busy vector.

Parameters:
- XLEN, 32, operand/data width
- TAG_W, 4, producer (ROB) tag width
- MY_TAG, ALU_1, this slot's RS_tag_type identity

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- DISPATCH_TASK  in  rs_task_t  task from dispatcher: opcode, func, dest_tag, {src1_rdy, src1_tag, src1_val}, {src2_rdy, src2_tag, src2_val}, imm
- DEST_RS  in  RS_tag_type  target slot of DISPATCH_TASK; INVALID = no dispatch
- FLUSH  in  1  squash held task (mispredict)
- CDB_VALID  in  1  CDB broadcast valid
- CDB_TAG  in  TAG_W  producer tag of broadcast
- CDB_DATA  in  XLEN  broadcast value
- BUSY  out  1  slot occupied; feeds rs_busy[MY_TAG]
- FU_VALID  out  1  operands complete, task presented to FU
- FU_READY  in  1  FU accepts task
- FU_TASK  out  rs_task_t  held task with resolved operands

Behaviour:
- Reset (async, RST=1): state=IDLE; BUSY=0, FU_VALID=0, FU_TASK=0. Reset mid-operation discards the held task.
- Accept: when state==IDLE and DEST_RS==MY_TAG, latch DISPATCH_TASK on the clock edge. BUSY=1 from the next cycle.
- Dispatch while BUSY: ignored. The dispatcher must not do this. Assertion: "dispatch to busy RS".
- States:
  - IDLE: waiting for a dispatch.
  - WAIT_OPS: at least one src_rdy==0.
  - ISSUE: both sources ready; FU_VALID=1.
- Transitions:
  - IDLE→WAIT_OPS on accept with an operand missing.
  - IDLE→ISSUE on accept with both operands ready, including operands captured this cycle.
  - WAIT_OPS→ISSUE the cycle after the last operand is captured.
  - ISSUE→IDLE when FU_VALID && FU_READY.
- Operand capture, in WAIT_OPS and on the accept cycle: for each source with rdy==0, if CDB_VALID && CDB_TAG==src_tag, then src_val←CDB_DATA and src_rdy←1.
  - One broadcast may satisfy both sources.
  - Capture in the accept cycle is mandatory (dispatch/broadcast race). Otherwise the broadcast is lost and the slot deadlocks.
- Latency: operands ready at dispatch → FU_VALID in cycle N+1. Last CDB broadcast in cycle M → FU_VALID in M+1.
- FU handshake:
  - FU_TASK is stable while FU_VALID=1 && !FU_READY.
  - FU_VALID never drops without a handshake, except on FLUSH/RST.
- BUSY is 1 in WAIT_OPS and ISSUE. It falls the cycle after the handshake, so the slot can accept a new dispatch one cycle after the handshake. No same-cycle reuse.
- FLUSH: next state IDLE, BUSY=0, FU_VALID=0. FLUSH has priority over accept and handshake in the same cycle.
- Only ALU slots use src2 from the bus. LOAD slots treat src2 as don't-care. src2_rdy is forced to 1 at accept when opcode==LOAD.

Optional Feature:
- Macro RS_PERF_CNT_EN.
- Defined:
  - Adds output WAIT_CYCLES, 16 bits. It counts cycles spent in WAIT_OPS plus cycles in ISSUE with FU_READY=0.
  - Saturates at 0xFFFF; cleared by RST only.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package cpu_types holds: RS_tag_type, existing opcode enum (LOAD, STORE, …), rs_task_t struct, operand_t struct {rdy, tag, val}, and state enum rs_state_t.
- One natural sub-module, rs_operand_capture. It takes an operand_t plus the CDB signals and returns the updated operand_t. It is instantiated twice, for src1 and src2.

Test Plan:
- Ready dispatch: DEST_RS=ALU_1, both rdy=1, src1=5, src2=7, FU_READY=1. Expect BUSY=1 and FU_VALID=1 next cycle with FU_TASK.src1_val=5, src2_val=7; BUSY=0 one cycle after the handshake.
- Wait-then-wake: src1_rdy=0 with tag 3, then CDB_VALID with tag 3 and data 0xDEAD two cycles later. Expect WAIT_OPS for 2 cycles, FU_VALID the cycle after the broadcast, src1_val=0xDEAD.
- Race: dispatch with src2 tag 9 and a CDB broadcast with tag 9 and data 42 in the same cycle. Expect FU_VALID next cycle with src2_val=42 (no deadlock).
- Backpressure: FU_READY=0 for 4 cycles. Expect FU_VALID and FU_TASK held constant; with RS_PERF_CNT_EN, WAIT_CYCLES=4.
- Flush and reset: FLUSH while in WAIT_OPS → BUSY=0 next cycle and a later matching CDB is ignored. RST asserted mid-ISSUE → outputs 0 immediately (asynchronously).
- Tag mismatch: DEST_RS=LOAD_2 presented to the ALU_1 instance → no accept, BUSY stays 0.
